enc_8b10b_rd: RTL and testbench



---
 rtl/enc_8b10b_rd_pkg.sv | 75 +++++++
 rtl/enc_8b10b_rd_if.sv | 21 ++
 rtl/enc_8b10b_rd_enc_3b4b.sv | 29 ++
 rtl/enc_8b10b_rd.sv | 99 +++++++++
 tb/tb_enc_8b10b_rd.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/enc_8b10b_rd_pkg.sv
// Shared constants, types and classification helpers for the 8b/10b encoder.
package enc8b10b_pkg;

    localparam logic [7:0] K28_5_BYTE = 8'hBC;
    localparam logic [7:0] K28_1_BYTE = 8'h3C;
    localparam logic       RD_NEG     = 1'b0;
    localparam logic       RD_POS     = 1'b1;

    // Field positions inside the 10-bit symbol (bit 0 leaves the serializer first)
    localparam int unsigned ABCDEI_LSB = 0;
    localparam int unsigned ABCDEI_MSB = 5;
    localparam int unsigned FGHJ_LSB   = 6;
    localparam int unsigned FGHJ_MSB   = 9;

    // Widmer-Franaszek L functions of bits A..D (count of ones / pairing)
    typedef struct packed {
        logic l40;
        logic l04;
        logic l13;
        logic l31;
        logic l22;
    } l_class_t;

    // Classes of the 3-bit FGH field that matter for 4b selection
    typedef enum logic [1:0] {
        C3_X0,
        C3_X3,
        C3_X7,
        C3_OTHER
    } cls3_t;

    // Stage-1 pipeline register contents
    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       k;
        logic       k_ok;
        logic       rd_force;
        l_class_t   l;
        cls3_t      cls3;
    } s1_t;

    function automatic logic is_valid_k(input logic [7:0] byte_in);
        logic [4:0] x;
        logic [2:0] y;
        x = byte_in[4:0];
        y = byte_in[7:5];
        return (x == 5'd28) ||
               ((y == 3'd7) && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));
    endfunction

    function automatic l_class_t classify_5b(input logic [3:0] abcd);
        logic a, b, c, d, a_eq_b, c_eq_d;
        l_class_t r;
        {d, c, b, a} = abcd;
        a_eq_b = ~(a ^ b);
        c_eq_d = ~(c ^ d);
        r.l40  = a & b & c & d;
        r.l04  = ~a & ~b & ~c & ~d;
        r.l13  = (~a_eq_b & ~c & ~d) | (~c_eq_d & ~a & ~b);
        r.l31  = (~a_eq_b & c & d) | (~c_eq_d & a & b);
        r.l22  = (a & b & ~c & ~d) | (c & d & ~a & ~b) | (~a_eq_b & ~c_eq_d);
        return r;
    endfunction

    function automatic cls3_t classify_3b(input logic [2:0] hgf);
        case (hgf)
            3'b000:  return C3_X0;
            3'b011:  return C3_X3;
            3'b111:  return C3_X7;
            default: return C3_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/enc_8b10b_rd_if.sv
// Byte-in / symbol-out bus of the 8b/10b encoder.
interface enc_8b10b_rd_if;
    logic       in_valid;
    logic [7:0] data_in;
    logic       k_in;
    logic       rd_force;
    logic       out_valid;
    logic [9:0] data_out;
    logic       rd_out;
    logic       code_err;

    modport master (
        output in_valid, data_in, k_in, rd_force,
        input  out_valid, data_out, rd_out, code_err
    );

    modport slave (
        input  in_valid, data_in, k_in, rd_force,
        output out_valid, data_out, rd_out, code_err
    );
endinterface

// File: rtl/enc_8b10b_rd_enc_3b4b.sv
// Combinational 3b/4b encoder: fghj selection and 4b disparity flag.
module enc_3b4b
    import enc8b10b_pkg::*;
(
    input  logic [2:0] fgh,     // {H,G,F}
    input  logic       k,
    input  logic       rd,      // RD after the 6b sub-block
    input  logic       a7_sel,
    output logic [3:0] fghj,    // bit 0 = f
    output logic       flip     // 4b block is unbalanced and toggles RD
);
    logic f, g, h;
    logic f_o, g_o, h_o, j_o;
    logic pd1s4, nd1s4, compl4;

    // Base code from FGH, then complement toward the side the RD allows
    always_comb begin
        {h, g, f} = fgh;
        f_o    = f & ~a7_sel;
        g_o    = g | (~f & ~g & ~h);
        h_o    = h;
        j_o    = (~h & (g ^ f)) | a7_sel;
        nd1s4  = f & g;
        pd1s4  = (~f & ~g) | (k & (f ^ g));
        compl4 = (rd == RD_NEG) ? pd1s4 : nd1s4;
        fghj   = {j_o, h_o, g_o, f_o} ^ {4{compl4}};
        flip   = (~f & ~g) | (f & g & h);
    end
endmodule

// File: rtl/enc_8b10b_rd.sv
// Two-stage pipelined 8b/10b encoder with running-disparity tracking.
module enc_8b10b_rd
    import enc8b10b_pkg::*;
#(
    parameter logic RD_INIT = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    enc_8b10b_rd_if.slave bus
);
    s1_t        s1_d, s1_q;
    logic       a, b, c, d, e;
    logic       ki, rd_cur, rd6, a7_sel;
    logic       pd1s6, nd1s6, flip6, compl6;
    logic [5:0] abcdei_raw;   // bit 0 = a
    logic [3:0] fghj;
    logic       flip4;
    logic [9:0] sym;
    logic       rd_next;
    logic       out_valid_q, rd_q, err_q;
    logic [9:0] data_q;

    // Stage 1 inputs: classify A-D and FGH, validate the K code
    always_comb begin
        s1_d          = '0;
        s1_d.valid    = bus.in_valid;
        s1_d.data     = bus.data_in;
        s1_d.k        = bus.k_in;
        s1_d.k_ok     = is_valid_k(bus.data_in);
        s1_d.rd_force = bus.rd_force;
        s1_d.l        = classify_5b(bus.data_in[3:0]);
        s1_d.cls3     = classify_3b(bus.data_in[7:5]);
    end

    // Stage 1 register
    always_ff @(posedge clk) begin
        if (!rst_n) s1_q <= '0;
        else        s1_q <= s1_d;
    end

    // Stage 2: 6b selection, intermediate RD and the A7 decision
    always_comb begin
        {e, d, c, b, a} = s1_q.data[4:0];
        // Invalid K codes fall back to the D code of the same byte
        ki     = s1_q.k & s1_q.k_ok;
        rd_cur = s1_q.rd_force ? RD_INIT : rd_q;
        abcdei_raw[0] = a;
        abcdei_raw[1] = (b & ~s1_q.l.l40) | s1_q.l.l04;
        abcdei_raw[2] = s1_q.l.l04 | c | (e & d & ~c & ~b & ~a);
        abcdei_raw[3] = d & ~(a & b & c);
        abcdei_raw[4] = (e | s1_q.l.l13) & ~(e & d & ~c & ~b & ~a);
        abcdei_raw[5] = (s1_q.l.l22 & ~e) | (e & ~d & ~c & ~(a & b)) | (e & s1_q.l.l40) |
                        (ki & e & d & c & ~b & ~a) | (e & ~d & c & ~b & ~a);
        // pd1s6: base code is -2 (complement at RD-); nd1s6: base is +2 or D.7
        pd1s6  = (e & d & ~c & ~b & ~a) | (~e & ~s1_q.l.l22 & ~s1_q.l.l31);
        nd1s6  = ki | (e & ~s1_q.l.l22 & ~s1_q.l.l13) | (~e & ~d & c & b & a);
        flip6  = pd1s6 | ki | (e & ~s1_q.l.l22 & ~s1_q.l.l13);
        compl6 = (rd_cur == RD_POS) ? nd1s6 : pd1s6;
        rd6    = rd_cur ^ flip6;
        // A7 candidates all have balanced 6b codes, so rd6 equals the entry RD here
        a7_sel = (s1_q.cls3 == C3_X7) &
                 (ki | ((rd6 == RD_POS) ? (~e & d & s1_q.l.l31) : (e & ~d & s1_q.l.l13)));
    end

    enc_3b4b u_enc_3b4b (
        .fgh    (s1_q.data[7:5]),
        .k      (ki),
        .rd     (rd6),
        .a7_sel (a7_sel),
        .fghj   (fghj),
        .flip   (flip4)
    );

    assign sym[ABCDEI_MSB:ABCDEI_LSB] = abcdei_raw ^ {6{compl6}};
    assign sym[FGHJ_MSB:FGHJ_LSB]     = fghj;
    assign rd_next                    = rd6 ^ flip4;

    // Stage 2 register: outputs and RD update only for valid inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            rd_q        <= RD_INIT;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= s1_q.valid;
            if (s1_q.valid) begin
                data_q <= sym;
                rd_q   <= rd_next;
                err_q  <= s1_q.k & ~s1_q.k_ok;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_q;
    assign bus.rd_out    = rd_q;
    assign bus.code_err  = err_q;
endmodule

// File: tb/tb_enc_8b10b_rd.sv
// Directed bench for enc_8b10b_rd: vector table plus reset/bubble/force sequences.
module tb_enc_8b10b_rd;
    import enc8b10b_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    enc_8b10b_rd_if bus ();

    enc_8b10b_rd #(.RD_INIT(RD_NEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       k;
        logic [9:0] sym;
        logic       rd;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    // Build a symbol from abcdei / fghj written in transmission order (a, f leftmost)
    function automatic logic [9:0] mk(input logic [5:0] s6, input logic [3:0] s4);
        logic [9:0] r;
        for (int i = 0; i < 6; i++) r[i] = s6[5 - i];
        for (int i = 0; i < 4; i++) r[6 + i] = s4[3 - i];
        return r;
    endfunction

    task automatic add_vec(input logic [7:0] d, input logic k, input logic [5:0] s6,
                           input logic [3:0] s4, input logic rd, input logic err);
        vec_t v;
        v.d   = d;
        v.k   = k;
        v.sym = mk(s6, s4);
        v.rd  = rd;
        v.err = err;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic k, input logic f);
        @(negedge clk);
        bus.in_valid = v;
        bus.data_in  = d;
        bus.k_in     = k;
        bus.rd_force = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic ev, input logic [9:0] es,
                       input logic erd, input logic eerr);
        tests++;
        if (bus.out_valid !== ev || bus.data_out !== es ||
            bus.rd_out !== erd || bus.code_err !== eerr) begin
            failed++;
            $display("FAIL %s: got v=%b sym=%b rd=%b err=%b, want v=%b sym=%b rd=%b err=%b",
                     name, bus.out_valid, bus.data_out, bus.rd_out, bus.code_err,
                     ev, es, erd, eerr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1);
    end

    initial begin
        int n;
        tests  = 0;
        failed = 0;

        add_vec(8'h00,      1'b0, 6'b100111, 4'b0100, 1'b0, 1'b0); // D.0.0 RD-
        add_vec(8'h00,      1'b0, 6'b100111, 4'b0100, 1'b0, 1'b0);
        add_vec(8'h00,      1'b0, 6'b100111, 4'b0100, 1'b0, 1'b0);
        add_vec(K28_5_BYTE, 1'b1, 6'b001111, 4'b1010, 1'b1, 1'b0); // K.28.5 RD-
        add_vec(K28_5_BYTE, 1'b1, 6'b110000, 4'b0101, 1'b0, 1'b0); // K.28.5 RD+
        add_vec(8'hB5,      1'b0, 6'b101010, 4'b1010, 1'b0, 1'b0); // D.21.5 RD-
        add_vec(K28_1_BYTE, 1'b1, 6'b001111, 4'b1001, 1'b1, 1'b0); // K.28.1 RD-
        add_vec(8'hB5,      1'b0, 6'b101010, 4'b1010, 1'b1, 1'b0); // D.21.5 RD+
        add_vec(8'h00,      1'b0, 6'b011000, 4'b1011, 1'b1, 1'b0); // D.0.0 RD+
        add_vec(K28_5_BYTE, 1'b1, 6'b110000, 4'b0101, 1'b0, 1'b0); // K.28.5 RD+
        add_vec(8'hF1,      1'b0, 6'b100011, 4'b0111, 1'b1, 1'b0); // D.17.7 RD- (A7)
        add_vec(8'hEB,      1'b0, 6'b110100, 4'b1000, 1'b0, 1'b0); // D.11.7 RD+ (A7)
        add_vec(8'h01,      1'b1, 6'b011101, 4'b0100, 1'b0, 1'b1); // bad K -> D.1.0 RD-
        add_vec(K28_5_BYTE, 1'b1, 6'b001111, 4'b1010, 1'b1, 1'b0); // K.28.5 RD-
        add_vec(8'h01,      1'b1, 6'b100010, 4'b1011, 1'b1, 1'b1); // bad K -> D.1.0 RD+
        add_vec(8'h07,      1'b0, 6'b000111, 4'b0100, 1'b0, 1'b0); // D.7.0 RD+
        add_vec(8'h67,      1'b0, 6'b111000, 4'b1100, 1'b0, 1'b0); // D.7.3 RD-
        add_vec(8'hFC,      1'b1, 6'b001111, 4'b1000, 1'b0, 1'b0); // K.28.7 RD-
        add_vec(8'hF7,      1'b1, 6'b111010, 4'b1000, 1'b0, 1'b0); // K.23.7 RD-
        add_vec(8'hFF,      1'b1, 6'b101011, 4'b0001, 1'b0, 1'b1); // bad K -> D.31.7 RD-

        // Reset with a valid input presented: reset must dominate
        rst_n = 1'b0;
        drive(1'b1, 8'hFF, 1'b1, 1'b1);
        tick();
        tick();
        chk("reset", 1'b0, 10'd0, RD_NEG, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Back-to-back stream; each symbol appears two edges after it is presented
        n = vecs.size();
        for (int i = 0; i < n; i++) begin
            drive(1'b1, vecs[i].d, vecs[i].k, 1'b0);
            tick();
            if (i == 0) chk("latency", 1'b0, 10'd0, RD_NEG, 1'b0);
            else        chk($sformatf("vec%0d", i - 1), 1'b1, vecs[i - 1].sym,
                            vecs[i - 1].rd, vecs[i - 1].err);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk($sformatf("vec%0d", n - 1), 1'b1, vecs[n - 1].sym, vecs[n - 1].rd, vecs[n - 1].err);

        // Mid-stream reset: reach RD+, then reset while D.21.5 is in flight
        drive(1'b1, K28_5_BYTE, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'hB5, 1'b0, 1'b0);
        tick();
        chk("pre_rst", 1'b1, mk(6'b001111, 4'b1010), RD_POS, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("rst_a", 1'b0, 10'd0, RD_NEG, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst_b", 1'b0, 10'd0, RD_NEG, 1'b0);
        drive(1'b0, K28_5_BYTE, 1'b1, 1'b1);
        tick();
        chk("rst_c", 1'b1, mk(6'b100111, 4'b0100), RD_NEG, 1'b0);

        // Bubbles (with rd_force and a bad K presented) hold outputs and RD
        drive(1'b1, K28_5_BYTE, 1'b1, 1'b0);
        tick();
        chk("bub_0", 1'b0, mk(6'b100111, 4'b0100), RD_NEG, 1'b0);
        drive(1'b0, 8'h01, 1'b1, 1'b1);
        tick();
        chk("k285", 1'b1, mk(6'b001111, 4'b1010), RD_POS, 1'b0);
        drive(1'b0, 8'h01, 1'b1, 1'b1);
        tick();
        chk("bub_a", 1'b0, mk(6'b001111, 4'b1010), RD_POS, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        tick();
        chk("bub_b", 1'b0, mk(6'b001111, 4'b1010), RD_POS, 1'b0);

        // rd_force applies to one symbol only
        drive(1'b1, K28_5_BYTE, 1'b1, 1'b1);
        tick();
        chk("bub_rd", 1'b1, mk(6'b011000, 4'b1011), RD_POS, 1'b0);
        drive(1'b1, K28_5_BYTE, 1'b1, 1'b0);
        tick();
        chk("force", 1'b1, mk(6'b001111, 4'b1010), RD_POS, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("after_force", 1'b1, mk(6'b110000, 4'b0101), RD_NEG, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
